step_scheduler: RTL and testbench
=================================

Name: step_scheduler

Overview:
- Tempo controller that sequences the 0–9 step counter datapath driving the drum pattern and 7-segment step display.
- Generates a programmable-rate step tick and keeps the current step index (up/down, programmable loop length).
- Has a run/pause/stop FSM fed by debounced button pulses.
- Downstream, sound triggers and the display decoder consume `step`, `step_tick` and `beat`.

Parameters:
- TICK_DIV, 12_500_000, base clock cycles per step at tempo_sel=0 (4 steps/s at 50 MHz); must be ≥8 and divisible by 4.
- STEP_W, 4, width of step index.
- MAX_STEPS, 10, maximum loop length; steps are 0..MAX_STEPS-1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- Re  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse: begin or restart playback.
- stop  in  1  one-cycle pulse: halt and return to idle.
- pause  in  1  one-cycle pulse: toggle RUN/PAUSE.
- dir  in  1  1 = count up, 0 = count down; sampled at each advance.
- tempo_sel  in  2  period select: 0 = TICK_DIV, 1 = TICK_DIV/2, 2 = TICK_DIV/4, 3 = TICK_DIV*2.
- loop_len  in  STEP_W  active step count 1..MAX_STEPS; 0 or >MAX_STEPS treated as MAX_STEPS.
- step  out  STEP_W  current step index.
- step_tick  out  1  one-cycle pulse each time a step becomes current (including the first).
- beat  out  1  one-cycle pulse coincident with step_tick when the new step is 0.
- running  out  1  high in RUN state only.

Behaviour:
- Reset: Re low at a clk edge forces the following, overriding all other inputs:
  - state=IDLE, step=0, prescaler=0;
  - step_tick=0, beat=0, running=0.
- Input priority per cycle: stop > start > pause.
- FSM states IDLE, RUN, PAUSE:
  - IDLE: start → RUN; pause ignored; stop holds IDLE.
  - RUN: stop → IDLE; start → restart; pause → PAUSE; otherwise count.
  - PAUSE: stop → IDLE; start → restart into RUN; pause → RUN, resuming prescaler from its held value with no step_tick.
- Start/restart:
  - Next cycle: step = 0 if dir=1, else L-1, where L is the effective loop_len.
  - Prescaler cleared, and step_tick (plus beat if step=0) pulses in that same cycle. Latency start→step_tick = 1 clk.
- Stop: step=0 and prescaler=0 on the next cycle; no tick is issued.
- Prescaler:
  - Counts 0..P-1 in RUN only; it holds in PAUSE and clears in IDLE.
  - When count==P-1, it wraps to 0 and the step advances with step_tick on the following cycle. First-to-second tick spacing is exactly P cycles.
- tempo_sel change mid-step: takes effect at the next prescaler wrap. If the current count ≥ new P-1, treat as a wrap on that cycle.
- Advance rule:
  - Up: step==L-1 or step≥L → 0.
  - Down: step==0 or step≥L → L-1.
  - Otherwise ±1.
  - loop_len change mid-run therefore takes effect at the next advance.
- beat is asserted exactly when step_tick=1 and the new step=0.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: STEP_SWING_EN.
- Defined:
  - Steps with even index last P + P/4 cycles; odd steps last P - P/4 cycles. Pair period is unchanged (2P).
  - Step duration is chosen by the index of the step that is current.
- Undefined: every step lasts P cycles; no swing logic is synthesized.

Decomposition:
- Package step_pkg holds:
  - typedef enum logic [1:0] sched_state_t {S_IDLE, S_RUN, S_PAUSE};
  - STEP_W and MAX_STEPS constants;
  - tempo_sel encoding localparams and the function eff_len(loop_len) → L.
- One natural sub-module: tick_prescaler. Inputs: clk, Re, en, clr, period. Output: wrap pulse.
- FSM and step arithmetic stay in step_scheduler.

Test Plan:
- Bench parameters for all scenarios: TICK_DIV=8, tempo_sel=0, loop_len=0.
- Reset mid-run: pulse start, wait 20 cycles, drop Re one cycle → step=0, running=0, and no step_tick thereafter until the next start.
- Up count: start with dir=1 → step_tick at cycle 1 with step=0 and beat=1, then every 8 cycles step 1..9. After step 9 → step=0 with beat=1.
- Down wrap plus loop_len:
  - loop_len=4, dir=0, start → step sequence 3, 2, 1, 0, 3, with beat only on 0.
  - Changing loop_len to 2 while at step 3 → next advance gives step=1.
- Pause/resume: pause 3 cycles after a tick, hold 50 cycles, pause again.
  - step frozen and no ticks during PAUSE.
  - Next tick arrives exactly 5 cycles after resume.
- Priority: start and stop asserted in the same cycle while RUN → IDLE, step=0, no tick. Start alone in PAUSE → restart at step 0 with an immediate tick.
- STEP_SWING_EN: tempo_sel=0, dir=1 → tick gaps alternate 10, 6, 10, 6 cycles. With the macro undefined, gaps are uniformly 8.

Source files
------------

// File: rtl/step_pkg.sv
// rtl/step_pkg.sv - shared types, constants and loop-length helper for step_scheduler
package step_pkg;

  localparam int STEP_W    = 4;
  localparam int MAX_STEPS = 10;

  localparam logic [1:0] TEMPO_BASE   = 2'd0;
  localparam logic [1:0] TEMPO_FAST   = 2'd1;
  localparam logic [1:0] TEMPO_FASTER = 2'd2;
  localparam logic [1:0] TEMPO_SLOW   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} sched_state_t;

  // Out-of-range loop lengths fall back to the full pattern.
  function automatic logic [STEP_W-1:0] eff_len(input logic [STEP_W-1:0] len);
    if (len == '0 || len > STEP_W'(MAX_STEPS)) return STEP_W'(MAX_STEPS);
    return len;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - step-period counter; wrap pulses on the last count of each period
module tick_prescaler #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             Re,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] period,
  output logic             wrap
);

  logic [CNT_W-1:0] cnt;

  // >= rather than == so a shorter period chosen mid-step wraps immediately.
  assign wrap = en && !clr && (cnt >= period - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!Re) begin
      cnt <= '0;
    end else if (clr || wrap) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/step_scheduler.sv
// rtl/step_scheduler.sv - tempo/step sequencer with run/pause/stop FSM; STEP_SWING_EN adds swing timing
module step_scheduler
  import step_pkg::*;
#(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic              clk,
  input  logic              Re,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              dir,
  input  logic [1:0]        tempo_sel,
  input  logic [STEP_W-1:0] loop_len,
  output logic [STEP_W-1:0] step,
  output logic              step_tick,
  output logic              beat,
  output logic              running
);

  localparam int CNT_W = $clog2(TICK_DIV * 3);

  sched_state_t      state, state_n;
  logic [STEP_W-1:0] step_n, len_eff, step_first, step_adv;
  logic              tick_n;
  logic [CNT_W-1:0]  base_p, period;
  logic              wrap, pre_clr, pre_en;

  always_comb begin
    base_p = CNT_W'(TICK_DIV);
    case (tempo_sel)
      TEMPO_FAST:   base_p = CNT_W'(TICK_DIV / 2);
      TEMPO_FASTER: base_p = CNT_W'(TICK_DIV / 4);
      TEMPO_SLOW:   base_p = CNT_W'(TICK_DIV * 2);
      default:      base_p = CNT_W'(TICK_DIV);
    endcase
  end

`ifdef STEP_SWING_EN
  // Long even steps, short odd steps; a pair still spans two base periods.
  assign period = step[0] ? (base_p - (base_p >> 2)) : (base_p + (base_p >> 2));
`else
  assign period = base_p;
`endif

  assign pre_clr = stop || start || (state == S_IDLE);
  assign pre_en  = (state == S_RUN);

  tick_prescaler #(.CNT_W(CNT_W)) u_prescaler (
    .clk    (clk),
    .Re     (Re),
    .en     (pre_en),
    .clr    (pre_clr),
    .period (period),
    .wrap   (wrap)
  );

  always_comb begin
    len_eff    = eff_len(loop_len);
    step_first = dir ? '0 : len_eff - STEP_W'(1);
    if (dir) begin
      step_adv = (step == len_eff - STEP_W'(1) || step >= len_eff) ? '0 : step + STEP_W'(1);
    end else begin
      step_adv = (step == '0 || step >= len_eff) ? len_eff - STEP_W'(1) : step - STEP_W'(1);
    end
  end

  always_comb begin
    state_n = state;
    step_n  = step;
    tick_n  = 1'b0;
    if (stop) begin
      state_n = S_IDLE;
      step_n  = '0;
    end else if (start) begin
      state_n = S_RUN;
      step_n  = step_first;
      tick_n  = 1'b1;
    end else begin
      case (state)
        S_RUN: begin
          if (pause) begin
            state_n = S_PAUSE;
          end else if (wrap) begin
            step_n = step_adv;
            tick_n = 1'b1;
          end
        end
        S_PAUSE: if (pause) state_n = S_RUN;
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!Re) begin
      state     <= S_IDLE;
      step      <= '0;
      step_tick <= 1'b0;
      beat      <= 1'b0;
      running   <= 1'b0;
    end else begin
      state     <= state_n;
      step      <= step_n;
      step_tick <= tick_n;
      beat      <= tick_n && (step_n == '0);
      running   <= (state_n == S_RUN);
    end
  end

endmodule

// File: tb/tb_step_scheduler.sv
// tb/tb_step_scheduler.sv - directed self-checking bench for step_scheduler (tracks STEP_SWING_EN)
module tb_step_scheduler;

  logic       clk = 1'b0;
  logic       Re = 1'b0;
  logic       start = 1'b0, stop = 1'b0, pause = 1'b0, dir = 1'b1;
  logic [1:0] tempo_sel = 2'd0;
  logic [3:0] loop_len = 4'd0;
  logic [3:0] step;
  logic       step_tick, beat, running;

  int n_chk = 0;
  int n_fail = 0;

  step_scheduler #(.TICK_DIV(8)) dut (
    .clk       (clk),
    .Re        (Re),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .dir       (dir),
    .tempo_sel (tempo_sel),
    .loop_len  (loop_len),
    .step      (step),
    .step_tick (step_tick),
    .beat      (beat),
    .running   (running)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Cycles spent by a step with index s at TICK_DIV=8, tempo_sel=0.
  function automatic int exp_gap(input int s);
`ifdef STEP_SWING_EN
    return (s % 2 == 0) ? 10 : 6;
`else
    return 8;
`endif
  endfunction

  // Advance until step_tick is seen; returns cycles elapsed, 999 on timeout.
  task automatic wait_tick(output int n);
    n = 999;
    for (int i = 1; i <= 100; i++) begin
      cyc();
      if (step_tick) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cyc(); stop = 1'b0;
  endtask

  task automatic pulse_pause();
    pause = 1'b1; cyc(); pause = 1'b0;
  endtask

  int gap, ticks, moved, prev;
  int down_seq [4] = '{2, 1, 0, 3};

  initial begin
    cyc(); cyc();
    expect_eq("rst_step", step, 0);
    expect_eq("rst_running", running, 0);
    expect_eq("rst_tick", step_tick, 0);
    expect_eq("rst_beat", beat, 0);
    Re = 1'b1;
    cyc();

    // Up count through the full pattern and back to 0.
    dir = 1'b1;
    pulse_start();
    expect_eq("up_first_tick", step_tick, 1);
    expect_eq("up_first_step", step, 0);
    expect_eq("up_first_beat", beat, 1);
    expect_eq("up_running", running, 1);
    for (int i = 1; i <= 10; i++) begin
      wait_tick(gap);
      expect_eq("up_gap", gap, exp_gap(i - 1));
      expect_eq("up_step", step, i % 10);
      expect_eq("up_beat", beat, (i == 10) ? 1 : 0);
    end

    // Reset mid-run.
    pulse_start();
    repeat (20) cyc();
    Re = 1'b0; cyc(); Re = 1'b1;
    expect_eq("midrst_step", step, 0);
    expect_eq("midrst_running", running, 0);
    expect_eq("midrst_tick", step_tick, 0);
    ticks = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (step_tick) ticks++;
    end
    expect_eq("midrst_no_ticks", ticks, 0);

    // Down count with loop_len=4, then shrink loop_len while at step 3.
    loop_len = 4'd4;
    dir = 1'b0;
    pulse_start();
    expect_eq("down_first_tick", step_tick, 1);
    expect_eq("down_first_step", step, 3);
    expect_eq("down_first_beat", beat, 0);
    prev = 3;
    for (int i = 0; i < 4; i++) begin
      wait_tick(gap);
      expect_eq("down_gap", gap, exp_gap(prev));
      expect_eq("down_step", step, down_seq[i]);
      expect_eq("down_beat", beat, (down_seq[i] == 0) ? 1 : 0);
      prev = down_seq[i];
    end
    loop_len = 4'd2;
    wait_tick(gap);
    expect_eq("shrink_step", step, 1);
    loop_len = 4'd0;
    pulse_stop();
    expect_eq("stop_running", running, 0);
    expect_eq("stop_step", step, 0);
    expect_eq("stop_tick", step_tick, 0);

    // Pause ignored in IDLE.
    pulse_pause();
    expect_eq("idle_pause_running", running, 0);

    // Pause 3 cycles after a tick, hold 50 cycles, resume.
    dir = 1'b1;
    pulse_start();
    repeat (3) cyc();
    pulse_pause();
    expect_eq("pause_running", running, 0);
    ticks = 0;
    moved = 0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (step_tick) ticks++;
      if (step != 4'd0) moved++;
    end
    expect_eq("pause_no_ticks", ticks, 0);
    expect_eq("pause_step_frozen", moved, 0);
    pulse_pause();
    expect_eq("resume_running", running, 1);
    expect_eq("resume_no_tick", step_tick, 0);
    wait_tick(gap);
    expect_eq("resume_gap", gap + 1, exp_gap(0) - 3);
    expect_eq("resume_step", step, 1);

    // Stop beats start in the same cycle.
    start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    expect_eq("prio_running", running, 0);
    expect_eq("prio_step", step, 0);
    expect_eq("prio_tick", step_tick, 0);

    // Start alone while paused restarts immediately at step 0.
    pulse_start();
    wait_tick(gap);
    expect_eq("pre_pause_step", step, 1);
    pulse_pause();
    repeat (5) cyc();
    pulse_start();
    expect_eq("restart_tick", step_tick, 1);
    expect_eq("restart_step", step, 0);
    expect_eq("restart_beat", beat, 1);
    expect_eq("restart_running", running, 1);
    wait_tick(gap);
    expect_eq("restart_gap", gap, exp_gap(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
